// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB over one shared memory port.
// Define MC_CTRL_PERF_EN to add the cycle_count/instr_count performance counters.
module multicycle_control #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src1,
    output logic       alu_src2,
    output logic       ext_op,
    output logic       lu_op,
    output logic       fault,
    output logic [2:0] state
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        K_ALU, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR, K_JALR
    } kind_e;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    if (TIMEOUT < 1 || CNT_W < 1) begin : g_param_check
        $error("multicycle_control: TIMEOUT and CNT_W must be >= 1");
    end

    state_e        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    kind_e         kind_q, kind_d;
    logic [1:0]    reg_dst_q, reg_dst_d;
    logic [1:0]    mem_to_reg_q, mem_to_reg_d;
    logic          alu_src1_q, alu_src1_d;
    logic          alu_src2_q, alu_src2_d;
    logic          ext_op_q, ext_op_d;
    logic          lu_op_q, lu_op_d;

    logic          legal;
    kind_e         dec_kind;
    logic [1:0]    dec_rd;
    logic [1:0]    dec_m2r;
    logic          dec_a1;
    logic          dec_a2;
    logic          dec_ext;
    logic          dec_lu;

    always_comb begin
        legal    = 1'b0;
        dec_kind = K_ALU;
        dec_rd   = 2'b00;
        dec_m2r  = 2'b00;
        dec_a1   = 1'b0;
        dec_a2   = 1'b0;
        dec_ext  = 1'b0;
        dec_lu   = 1'b0;
        case (opcode)
            6'h00: begin
                dec_rd = 2'b01;
                case (funct)
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                    6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: legal = 1'b1;
                    6'h00, 6'h02, 6'h03: begin
                        legal  = 1'b1;
                        dec_a1 = 1'b1;
                    end
                    6'h08: begin
                        legal    = 1'b1;
                        dec_kind = K_JR;
                        dec_rd   = 2'b00;
                    end
                    6'h09: begin
                        legal    = 1'b1;
                        dec_kind = K_JALR;
                        dec_m2r  = 2'b10;
                    end
                    default: legal = 1'b0;
                endcase
            end
            6'h02: begin
                legal    = 1'b1;
                dec_kind = K_J;
            end
            6'h03: begin
                legal    = 1'b1;
                dec_kind = K_JAL;
                dec_rd   = 2'b10;
                dec_m2r  = 2'b10;
            end
            6'h04: begin
                legal    = 1'b1;
                dec_kind = K_BEQ;
                dec_ext  = 1'b1;
            end
            6'h23: begin
                legal    = 1'b1;
                dec_kind = K_LW;
                dec_m2r  = 2'b01;
                dec_a2   = 1'b1;
                dec_ext  = 1'b1;
            end
            6'h2b: begin
                legal    = 1'b1;
                dec_kind = K_SW;
                dec_a2   = 1'b1;
                dec_ext  = 1'b1;
            end
            6'h0f: begin
                legal  = 1'b1;
                dec_a2 = 1'b1;
                dec_lu = 1'b1;
            end
            // andi zero-extends its immediate
            6'h0c: begin
                legal  = 1'b1;
                dec_a2 = 1'b1;
            end
            6'h08, 6'h09, 6'h0a, 6'h0b: begin
                legal   = 1'b1;
                dec_a2  = 1'b1;
                dec_ext = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        kind_d       = kind_q;
        reg_dst_d    = reg_dst_q;
        mem_to_reg_d = mem_to_reg_q;
        alu_src1_d   = alu_src1_q;
        alu_src2_d   = alu_src2_q;
        ext_op_d     = ext_op_q;
        lu_op_d      = lu_op_q;
        if (state_q == S_DECODE && legal) begin
            kind_d       = dec_kind;
            reg_dst_d    = dec_rd;
            mem_to_reg_d = dec_m2r;
            alu_src1_d   = dec_a1;
            alu_src2_d   = dec_a2;
            ext_op_d     = dec_ext;
            lu_op_d      = dec_lu;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        i_or_d    = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'b00;
        reg_write = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECODE: state_d = legal ? S_EXEC : S_FAULT;
            S_EXEC: begin
                case (kind_q)
                    K_LW, K_SW: state_d = S_MEM;
                    K_BEQ: begin
                        pc_write = zero;
                        pc_src   = 2'b11;
                        state_d  = S_FETCH;
                    end
                    K_J, K_JAL: begin
                        pc_write  = 1'b1;
                        pc_src    = 2'b01;
                        reg_write = (kind_q == K_JAL);
                        state_d   = S_FETCH;
                    end
                    K_JR, K_JALR: begin
                        pc_write  = 1'b1;
                        pc_src    = 2'b10;
                        reg_write = (kind_q == K_JALR);
                        state_d   = S_FETCH;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                mem_we  = (kind_q == K_SW);
                if (mem_ready) begin
                    if (kind_q == K_LW) begin
                        ir_write = 1'b1;
                        state_d  = S_WB;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FAULT;
        endcase
        // Keep the memory and register file quiet while reset is held
        if (reset) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            i_or_d    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            pc_src    = 2'b00;
            reg_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            cnt_q        <= '0;
            kind_q       <= K_ALU;
            reg_dst_q    <= 2'b00;
            mem_to_reg_q <= 2'b00;
            alu_src1_q   <= 1'b0;
            alu_src2_q   <= 1'b0;
            ext_op_q     <= 1'b0;
            lu_op_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            kind_q       <= kind_d;
            reg_dst_q    <= reg_dst_d;
            mem_to_reg_q <= mem_to_reg_d;
            alu_src1_q   <= alu_src1_d;
            alu_src2_q   <= alu_src2_d;
            ext_op_q     <= ext_op_d;
            lu_op_q      <= lu_op_d;
        end
    end

    assign reg_dst    = reg_dst_q;
    assign mem_to_reg = mem_to_reg_q;
    assign alu_src1   = alu_src1_q;
    assign alu_src2   = alu_src2_q;
    assign ext_op     = ext_op_q;
    assign lu_op      = lu_op_q;
    assign fault      = (state_q == S_FAULT);
    assign state      = state_q;

`ifdef MC_CTRL_PERF_EN
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic             retire;

    always_comb begin
        retire = (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB)
                 && state_d == S_FETCH;
        cycle_count_d = cycle_count_q;
        instr_count_d = instr_count_q;
        if (state_q != S_FAULT) begin
            cycle_count_d = cycle_count_q + 1'b1;
        end
        if (retire) begin
            instr_count_d = instr_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count_q <= '0;
            instr_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;
`endif

endmodule
